vga_rx_monitor: RTL and testbench

VGA_RX_MONITOR -- requirements
Module: vga_rx_monitor

---
 rtl/vga_pkg.sv | 14 +
 rtl/crc16_ccitt_byte.sv | 17 +
 rtl/vga_rx_monitor.sv | 128 ++++++++++++
 tb/tb_vga_rx_monitor.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: lock-state type, CRC-16-CCITT constants and default 640x480@60 timing
// shared by the VGA receive monitor and its CRC helper.
package vga_pkg;
    typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} lock_state_e;
    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;
    localparam int VGA_H_TOTAL  = 800;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_START  = 144;
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_V_TOTAL  = 525;
    localparam int VGA_V_START  = 35;
    localparam int VGA_V_ACTIVE = 480;
endpackage

// File: rtl/crc16_ccitt_byte.sv
// crc16_ccitt_byte: combinational next CRC-16-CCITT after one byte, MSB first,
// no reflection.
module crc16_ccitt_byte
    import vga_pkg::*;
(
    input  logic [15:0] crc_i,
    input  logic [7:0]  byte_i,
    output logic [15:0] crc_o
);
    logic [15:0] c;
    always_comb begin
        c = crc_i ^ {byte_i, 8'h00};
        for (int i = 0; i < 8; i++)
            c = c[15] ? ({c[14:0], 1'b0} ^ CRC_POLY) : {c[14:0], 1'b0};
        crc_o = c;
    end
endmodule

// File: rtl/vga_rx_monitor.sv
// vga_rx_monitor: measures incoming VGA sync timing, locks onto a stable raster,
// emits active-pixel coordinates and a per-frame CRC of the pixel stream.
module vga_rx_monitor
    import vga_pkg::*;
#(
    parameter int H_TOTAL  = VGA_H_TOTAL,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_START  = VGA_H_START,
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int V_TOTAL  = VGA_V_TOTAL,
    parameter int V_START  = VGA_V_START,
    parameter int V_ACTIVE = VGA_V_ACTIVE
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [5:0]  rgb_in,
    input  logic        err_clr,
    output logic        locked,
    output logic        pixel_valid,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic [5:0]  pixel,
    output logic [9:0]  line_len,
    output logic [9:0]  lines_per_frame,
    output logic [15:0] frame_crc,
    output logic        crc_valid,
    output logic [2:0]  err
);
    localparam logic [9:0] HT  = 10'(H_TOTAL);
    localparam logic [9:0] HS  = 10'(H_SYNC);
    localparam logic [9:0] VT  = 10'(V_TOTAL);
    localparam logic [9:0] HX0 = 10'(H_START);
    localparam logic [9:0] HX1 = 10'(H_START + H_ACTIVE);
    localparam logic [9:0] VY0 = 10'(V_START);
    localparam logic [9:0] VY1 = 10'(V_START + V_ACTIVE);

    lock_state_e state_q, state_d;
    logic        hs_q, hs_p_q, vs_q, vs_p_q, clr_q, skip_q, skip_d;
    logic [5:0]  rgb_q, pix_q;
    logic [9:0]  hcnt_q, hcnt_d, hcnt_inc, vline_q, vline_d, line_len_q, line_len_d, lpf_q, lpf_d;
    logic [9:0]  x_q, x_d, y_q, y_d;
    logic        pv_q, pv_d, strobe, crc_valid_q;
    logic [15:0] crc_q, crc_d, crc_nx, frame_crc_q, frame_crc_d;
    logic [2:0]  err_q, err_d, mm;
    logic        hs_fall, hs_rise, vs_fall;

    assign hs_fall  = hs_p_q & ~hs_q;
    assign hs_rise  = ~hs_p_q & hs_q;
    assign vs_fall  = vs_p_q & ~vs_q;
    assign hcnt_inc = &hcnt_q ? hcnt_q : hcnt_q + 10'd1;

    crc16_ccitt_byte u_crc (.crc_i(crc_q), .byte_i({2'b00, pix_q}), .crc_o(crc_nx));

    always_comb begin
        hcnt_d     = hs_fall ? 10'd0 : hcnt_inc;
        line_len_d = hs_fall ? hcnt_inc : line_len_q;
        vline_d    = vs_fall ? 10'd0 : hs_fall ? (&vline_q ? vline_q : vline_q + 10'd1) : vline_q;
        lpf_d      = vs_fall ? vline_q : lpf_q;
        // The first line measured after SEARCH may be a fragment, so it is not judged.
        mm = {vs_fall && vline_q != VT, hs_rise && hcnt_inc != HS, hs_fall && !skip_q && hcnt_inc != HT};
        skip_d  = (state_q == SEARCH) | (skip_q & ~hs_fall);
        state_d = state_q;
        unique case (state_q)
            SEARCH:  state_d = vs_fall ? CHECK : SEARCH;
            CHECK:   state_d = |mm ? SEARCH : vs_fall ? LOCKED : CHECK;
            LOCKED:  state_d = |mm ? SEARCH : LOCKED;
            default: state_d = SEARCH;
        endcase
        pv_d = state_q == LOCKED && hcnt_d >= HX0 && hcnt_d < HX1 && vline_d >= VY0 && vline_d < VY1;
        x_d  = pv_d ? hcnt_d - HX0 : 10'd0;
        y_d  = pv_d ? vline_d - VY0 : 10'd0;
        strobe      = vs_fall && state_q == LOCKED && state_d == LOCKED;
        crc_d       = (vs_fall || state_d != LOCKED) ? CRC_INIT : pv_q ? crc_nx : crc_q;
        frame_crc_d = strobe ? crc_q : frame_crc_q;
        err_d       = (err_q & {3{~clr_q}}) | (state_q != SEARCH ? mm : 3'b000);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            {hs_q, hs_p_q, vs_q, vs_p_q} <= 4'b1111;
            {clr_q, pv_q, crc_valid_q}   <= 3'b000;
            skip_q      <= 1'b1;
            state_q     <= SEARCH;
            rgb_q       <= '0;
            pix_q       <= '0;
            hcnt_q      <= '0;
            vline_q     <= '0;
            line_len_q  <= '0;
            lpf_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            crc_q       <= CRC_INIT;
            frame_crc_q <= '0;
            err_q       <= '0;
        end else begin
            {hs_q, hs_p_q, vs_q, vs_p_q} <= {hsync_in, hs_q, vsync_in, vs_q};
            clr_q       <= err_clr;
            rgb_q       <= rgb_in;
            pix_q       <= rgb_q;
            skip_q      <= skip_d;
            state_q     <= state_d;
            hcnt_q      <= hcnt_d;
            vline_q     <= vline_d;
            line_len_q  <= line_len_d;
            lpf_q       <= lpf_d;
            pv_q        <= pv_d;
            x_q         <= x_d;
            y_q         <= y_d;
            crc_q       <= crc_d;
            frame_crc_q <= frame_crc_d;
            crc_valid_q <= strobe;
            err_q       <= err_d;
        end
    end

    assign locked          = state_q == LOCKED;
    assign pixel_valid     = pv_q;
    assign x               = x_q;
    assign y               = y_q;
    assign pixel           = pix_q;
    assign line_len        = line_len_q;
    assign lines_per_frame = lpf_q;
    assign frame_crc       = frame_crc_q;
    assign crc_valid       = crc_valid_q;
    assign err             = err_q;
endmodule

// File: tb/tb_vga_rx_monitor.sv
// tb_vga_rx_monitor: scaled-down raster (40x20 total, 24x12 active); expected pixels
// and frame CRCs are queued by the stimulus and consumed by an output monitor.
module tb_vga_rx_monitor;
    localparam int HT = 40, HSW = 6, HST = 10, HA = 24, VT = 20, VST = 4, VA = 12;

    logic        clk = 0, rst_n = 0, hsync_in = 1, vsync_in = 1, err_clr = 0;
    logic [5:0]  rgb_in = 0;
    logic        locked, pixel_valid, crc_valid;
    logic [9:0]  x, y, line_len, lines_per_frame;
    logic [5:0]  pixel;
    logic [15:0] frame_crc;
    logic [2:0]  err;

    vga_rx_monitor #(.H_TOTAL(HT), .H_SYNC(HSW), .H_START(HST), .H_ACTIVE(HA),
                     .V_TOTAL(VT), .V_START(VST), .V_ACTIVE(VA)) dut (
        .clk(clk), .rst_n(rst_n), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .rgb_in(rgb_in), .err_clr(err_clr), .locked(locked), .pixel_valid(pixel_valid),
        .x(x), .y(y), .pixel(pixel), .line_len(line_len), .lines_per_frame(lines_per_frame),
        .frame_crc(frame_crc), .crc_valid(crc_valid), .err(err));

    always #5 clk = ~clk;

    int          n_cmp = 0, n_fail = 0, rcnt = 0, pv_cnt = 0;
    logic [25:0] pix_q[$];
    logic [15:0] crc_q[$];
    logic [15:0] model_crc = 16'hFFFF, last_crc = 16'h0000;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Bit-serial LFSR form of CRC-16-CCITT.
    function automatic logic [15:0] crc_bits(input logic [15:0] c, input logic [7:0] d);
        for (int i = 7; i >= 0; i--)
            c = {c[14:0], 1'b0} ^ ((c[15] ^ d[i]) ? 16'h1021 : 16'h0000);
        return c;
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_ctrl"}, {locked, pixel_valid, crc_valid, err, x, y, pixel}, 64'd0);
        check({tag, "_meas"}, {line_len, lines_per_frame, frame_crc}, 64'd0);
    endtask

    // One frame; pixels are expected only if exp_pix and before (lf,lh).
    task automatic frame(input int nl, input bit exp_pix, input bit exp_crc, input int lf,
                         input int lh, input int long_l, input int short_l, input int clr_l,
                         input int rst_l, input bit cst);
        for (int f = 0; f < nl; f++) begin
            for (int h = 0; h < ((f == long_l) ? HT + 1 : HT); h++) begin
                @(negedge clk);
                if (rcnt > 0) begin
                    rcnt--;
                    if (rcnt == 0) rst_n = 1;
                end
                if (f == rst_l && h == 20) begin
                    rst_n = 0;
                    rcnt = 5;
                end
                if (rcnt == 2) check_zero("midrst");
                err_clr  = (f == clr_l && h == 5);
                hsync_in = (h >= ((f == short_l) ? HSW - 1 : HSW));
                vsync_in = !((f == 0 && h >= 2) || f == 1 || (f == 2 && h < 2));
                if (f == 0 && h == 2) begin
                    if (exp_crc) begin
                        crc_q.push_back(model_crc);
                        last_crc = model_crc;
                    end
                    model_crc = 16'hFFFF;
                end
                rgb_in = cst ? 6'h3F : 6'(f * 7 + h * 3);
                if (exp_pix && f >= VST && f < VST + VA && h >= HST && h < HST + HA &&
                    (f < lf || (f == lf && h < lh))) begin
                    pix_q.push_back({10'(h - HST), 10'(f - VST), rgb_in});
                    model_crc = crc_bits(model_crc, {2'b00, rgb_in});
                end
            end
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (pixel_valid) begin
            pv_cnt++;
            if (pix_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL pixel_unexpected: got x=%0d y=%0d pixel=%0h, required no pixel", x, y, pixel);
            end else check("pixel_xyp", {x, y, pixel}, pix_q.pop_front());
        end
        if (crc_valid) begin
            if (crc_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL crc_unexpected: got strobe crc=%0h, required no strobe", frame_crc);
            end else check("frame_crc", frame_crc, crc_q.pop_front());
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1;
        repeat (3) @(negedge clk);
        frame(20, 0, 0, 99, 0, -1, -1, -1, -1, 0);
        check("f1_locked", locked, 0);
        frame(20, 1, 0, 99, 0, -1, -1, -1, -1, 0);
        check("f2_locked", locked, 1);
        check("f2_err", err, 0);
        check("f2_line_len", line_len, HT);
        check("f2_lpf", lines_per_frame, VT);
        pv_cnt = 0;
        frame(20, 1, 1, 99, 0, -1, -1, -1, -1, 1);
        check("const_pv_count", pv_cnt, HA * VA);
        frame(20, 1, 1, 7, 0, 6, -1, -1, -1, 0);
        check("long_err", err, 3'b001);
        check("long_locked", locked, 0);
        check("long_crc_hold", frame_crc, last_crc);
        frame(20, 0, 0, 99, 0, -1, -1, 5, -1, 0);
        check("clr1_err", err, 0);
        frame(20, 1, 0, 99, 0, -1, -1, -1, -1, 0);
        check("relock1", locked, 1);
        frame(20, 1, 1, 8, 0, -1, 8, -1, -1, 0);
        check("hsw_err", err, 3'b010);
        check("hsw_locked", locked, 0);
        frame(20, 0, 0, 99, 0, -1, -1, 5, -1, 0);
        check("clr2_err", err, 0);
        frame(20, 1, 0, 99, 0, -1, -1, -1, -1, 0);
        frame(VT - 1, 1, 1, 99, 0, -1, -1, -1, -1, 0);
        frame(20, 0, 0, 99, 0, -1, -1, -1, -1, 0);
        check("short_frame_err", err, 3'b100);
        check("short_frame_lpf", lines_per_frame, VT - 1);
        check("short_frame_locked", locked, 0);
        frame(20, 0, 0, 99, 0, -1, -1, -1, -1, 0);
        check("recheck_locked", locked, 0);
        frame(20, 1, 0, 99, 0, -1, -1, -1, -1, 0);
        check("relock2", locked, 1);
        frame(20, 1, 1, 6, 19, -1, -1, -1, 6, 0);
        check("post_rst_locked", locked, 0);
        check("post_rst_crc", frame_crc, 0);
        frame(20, 0, 0, 99, 0, -1, -1, -1, -1, 0);
        check("post_rst_check", locked, 0);
        frame(20, 1, 0, 99, 0, -1, -1, -1, -1, 0);
        check("post_rst_relock", locked, 1);
        frame(20, 1, 1, 99, 0, -1, -1, -1, -1, 0);
        repeat (10) @(negedge clk);
        check("pix_left", pix_q.size(), 0);
        check("crc_left", crc_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
